// File: rtl/runway_pkg.sv
// Shared types and board constants for the runway-lights design.
// Imported by the input conditioner and by the lights FSM.
package runway_pkg;

  typedef enum logic [1:0] {
    CALM = 2'b00,
    W0   = 2'b01,
    W1   = 2'b10,
    BOTH = 2'b11
  } wind_t;

  localparam int CLK_HZ                  = 50_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50_000;
  localparam int DEFAULT_TICK_DIV        = 25_000_000;

  // A counter that must hold values up to maxCount-1; a single state still needs one bit.
  function automatic int counter_width(input int maxCount);
    return (maxCount <= 1) ? 1 : $clog2(maxCount);
  endfunction

endpackage

// File: rtl/wind_input_conditioner_if.sv
// Bundle between the board switches, the input conditioner and the lights stage.
// The conditioner sits on the slave side; whoever supplies switches and consumes wind/step is the master.
interface wind_input_conditioner_if import runway_pkg::*; ();

  logic [1:0] sw_raw;
  wind_t      wind;
  logic       wind_changed;
  logic       step;

  modport master (
    output sw_raw,
    input  wind,
    input  wind_changed,
    input  step
  );

  modport slave (
    input  sw_raw,
    output wind,
    output wind_changed,
    output step
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle step pulse every TICK_DIV clocks.
// The pulse is gated by reset so it is low in every cycle that reset is held.
module tick_gen import runway_pkg::*; #(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic step
);

  localparam int            TW        = counter_width(TICK_DIV);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;

  always_comb begin
    tcnt_d = (tcnt_q == TCNT_LAST) ? '0 : tcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign step = !reset && (tcnt_q == TCNT_LAST);

endmodule

// File: rtl/wind_input_conditioner.sv
// Synchronizes and debounces the raw wind switches and provides the lights-stage step enable.
// Both wind bits move through one candidate register so a commit never exposes a mixed code.
module wind_input_conditioner import runway_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEFAULT_TICK_DIV
) (
  input  logic                     clk,
  input  logic                     reset,
  wind_input_conditioner_if.slave  bus
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  wind_t         cand_q;
  wind_t         cand_d;
  wind_t         wind_q;
  wind_t         wind_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          changed_q;
  logic          changed_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= bus.sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // The counter only runs while a candidate differs from the committed code, so it stops at CNT_LAST.
  always_comb begin
    cand_d    = cand_q;
    wind_d    = wind_q;
    cnt_d     = cnt_q;
    changed_d = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = wind_t'(sync2_q);
      cnt_d  = '0;
    end else if (cand_q == wind_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      wind_d    = cand_q;
      cnt_d     = '0;
      changed_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q    <= CALM;
      wind_q    <= CALM;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      wind_q    <= wind_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  assign bus.wind         = wind_q;
  assign bus.wind_changed = changed_q;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .step  (bus.step)
  );

endmodule

// File: doc/wind_input_conditioner.md
Name: wind_input_conditioner

Overview:
Upstream stage of the runway-lights FSM. It takes the raw, asynchronous, bouncy wind switches (sw_raw[1] = w1, sw_raw[0] = w0) and turns them into two clean signals:
- a synchronized, debounced wind code that drives w1/w0;
- a one-cycle step pulse, divided down from the board clock, that the lights stage uses as its advance enable.

All inputs reach the lights FSM only through this block.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles after synchronization before a new wind code is committed (>=1).
TICK_DIV, 25000000, step period in clk cycles (>=1); 0.5 s at 50 MHz.

Ports:
clk  input  1  system clock; all state on posedge.
reset  input  1  synchronous, active-high reset.
sw_raw  input  2  raw wind switches; asynchronous to clk, may bounce.
wind  output  2  committed wind code: wind[1] -> w1, wind[0] -> w0.
wind_changed  output  1  one-cycle pulse in the cycle wind takes a new value.
step  output  1  one-cycle advance pulse for the lights FSM.

Behaviour:
- Reset values (sampled on posedge while reset = 1):
  - sync flops, candidate and debounce counter all 0;
  - wind = 2'b00 (CALM);
  - wind_changed = 0;
  - step = 0;
  - tick counter = 0.
- Reset overrides everything, including a debounce in progress; no partial state survives.
- Synchronizer: two flops per bit (sync1 then sync2). Only sync2 feeds later logic.
- Debounce, per clock:
  - If sync2 != cand: cand <= sync2, cnt <= 0.
  - Else if cand == wind: cnt <= 0 (idle).
  - Else if cnt == DEBOUNCE_CYCLES-1: wind <= cand, cnt <= 0, and wind_changed is 1 in the following cycle.
  - Else: cnt <= cnt + 1.
- Debounce width: cnt is $clog2(DEBOUNCE_CYCLES+1) bits and never wraps.
- Latency:
  - A clean raw change first sampled at edge E appears on wind after edge E+2+DEBOUNCE_CYCLES.
  - Any change of sync2 before that restarts the count.
  - A pulse shorter than DEBOUNCE_CYCLES cycles (after sync) never reaches wind.
- Both bits are committed together; wind never shows a mixed intermediate code.
- Code 2'b11 is committed like any other code; it is not filtered here.
- wind_changed: exactly one cycle wide, and never asserted for a commit of an unchanged value.
- Tick:
  - tcnt counts 0..TICK_DIV-1 and then wraps to 0.
  - step = 1 exactly in cycles where tcnt == TICK_DIV-1, so the first step comes in the TICK_DIV-th cycle after reset release.
  - step period is TICK_DIV; duty is 1 cycle.
  - With TICK_DIV = 1, step is 1 in every non-reset cycle.
- Tick and debounce are independent. A commit in the same cycle as step is legal; the lights stage samples the wind value present that cycle.

Decomposition:
- Package runway_pkg holds:
  - wind_t enum logic [1:0]: CALM = 2'b00, W0 = 2'b01, W1 = 2'b10, BOTH = 2'b11;
  - CLK_HZ = 50000000;
  - the default DEBOUNCE_CYCLES and TICK_DIV values.
- The runway-lights FSM imports the same package.
- One sub-module: tick_gen (parameter TICK_DIV; ports clk, reset, step). The synchronizer and debounce stay inline.

Test Plan (DEBOUNCE_CYCLES = 4, TICK_DIV = 8):
1. reset = 1 for 3 cycles with sw_raw = 2'b11 -> wind = 00, wind_changed = 0, step = 0 during reset; after release, step is high in cycles 8, 16, 24 and low otherwise.
2. sw_raw 00 -> 01, first sampled at edge E, then held -> wind = 01 after edge E+6 (not before); wind_changed high for that one cycle only.
3. sw_raw = 10 for 3 cycles, then back to 00 -> wind stays 00 and wind_changed is never asserted.
4. sw_raw alternates 10/00 every cycle for 10 cycles, then holds 10 -> wind = 10 exactly 6 edges after the last transition is first sampled; a single wind_changed pulse.
5. sw_raw = 10 held for 4 cycles, one reset cycle asserted, sw_raw still 10 -> wind = 00 immediately after reset; wind = 10 six edges after the first post-reset sample; tick restarts (next step in cycle 8 after release).
6. Build with TICK_DIV = 1 -> step = 1 in every cycle after reset release; wind path unaffected.
